neuron: RTL and testbench

NEURON -- requirements
Module: neuron

---
 rtl/neuron_pkg.sv | 12 +
 rtl/neuron_sat_add.sv | 37 +++
 rtl/neuron.sv | 64 ++++++
 tb/tb_neuron.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared width and clamp constants for the neuron multiply-accumulate datapath.
package neuron_pkg;

    localparam int WEIGHT_W = 19;
    localparam int PIXEL_W  = 10;
    localparam int PROD_W   = WEIGHT_W + PIXEL_W;
    localparam int ACC_W    = 26;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage : neuron_pkg

// File: rtl/neuron_sat_add.sv
// Stateless saturating adder: product + accumulator, clamped to the accumulator range.
module neuron_sat_add
    import neuron_pkg::*;
#(
    parameter int PROD_W = neuron_pkg::PROD_W,
    parameter int ACC_W  = neuron_pkg::ACC_W
) (
    input  logic signed [PROD_W-1:0] prod_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    // One guard bit above the wider operand makes the raw sum exact.
    localparam int SUM_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

    logic signed [SUM_W-1:0] prod_ext;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] sum_full;

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no path can leave a value held and infer a latch.
    always_comb begin
        prod_ext = {{(SUM_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
        acc_ext  = {{(SUM_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
        sum_full = prod_ext + acc_ext;
        sum_o    = sum_full[ACC_W-1:0];
        if (sum_full > SUM_MAX) begin
            sum_o = SUM_MAX[ACC_W-1:0];
        end else if (sum_full < SUM_MIN) begin
            sum_o = SUM_MIN[ACC_W-1:0];
        end
    end

endmodule : neuron_sat_add

// File: rtl/neuron.sv
// Two-stage pipelined neuron: signed weight x unsigned pixel product register,
// followed by a saturating accumulator that drives Out_o straight from a flop.
module neuron
    import neuron_pkg::*;
#(
    parameter int WEIGHT_W = neuron_pkg::WEIGHT_W,
    parameter int PIXEL_W  = neuron_pkg::PIXEL_W,
    parameter int ACC_W    = neuron_pkg::ACC_W
) (
    input  logic                       Clk_i,
    input  logic                       GlobalReset_i,
    input  logic signed [WEIGHT_W-1:0] Weight_i,
    input  logic        [PIXEL_W-1:0]  Pixel_i,
    input  logic                       Mult_en_i,
    input  logic                       Add_en_i,
    output logic signed [ACC_W-1:0]    Out_o
);

    localparam int PRODUCT_W = WEIGHT_W + PIXEL_W;

    logic signed [PRODUCT_W-1:0] weight_ext;
    logic signed [PRODUCT_W-1:0] pixel_ext;
    logic signed [PRODUCT_W-1:0] prod_d, prod_q;
    logic signed [ACC_W-1:0]     acc_d, acc_q;
    logic signed [ACC_W-1:0]     sat_sum;

    neuron_sat_add #(
        .PROD_W (PRODUCT_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .prod_i (prod_q),
        .acc_i  (acc_q),
        .sum_o  (sat_sum)
    );

    // The pixel gets a zero top bit, so the signed product is exact in PRODUCT_W bits.
    always_comb begin
        weight_ext = {{(PRODUCT_W-WEIGHT_W){Weight_i[WEIGHT_W-1]}}, Weight_i};
        pixel_ext  = {{(PRODUCT_W-PIXEL_W){1'b0}}, Pixel_i};
        prod_d     = '0;
        acc_d      = acc_q;
        if (Mult_en_i) begin
            prod_d = weight_ext * pixel_ext;
        end
        if (Add_en_i) begin
            acc_d = sat_sum;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values and the two stages advance together without races.
    always_ff @(posedge Clk_i) begin
        if (GlobalReset_i) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign Out_o = acc_q;

endmodule : neuron

// File: tb/tb_neuron.sv
// Self-checking bench for neuron: directed cases with literal expectations plus
// a randomized stream compared every cycle against a behavioural model.
module tb_neuron;
    import neuron_pkg::*;

    localparam longint MAX_V = 33554431;
    localparam longint MIN_V = -33554432;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic signed [WEIGHT_W-1:0] weight = '0;
    logic        [PIXEL_W-1:0]  pixel = '0;
    logic                       mult_en = 1'b0;
    logic                       add_en = 1'b0;
    logic signed [ACC_W-1:0]    out;

    int tests = 0;
    int fails = 0;

    // Model: the product waiting to be added and the value Out_o must show.
    longint m_pending = 0;
    longint m_acc = 0;
    bit     m_valid = 1'b0;

    neuron #(
        .WEIGHT_W (WEIGHT_W),
        .PIXEL_W  (PIXEL_W),
        .ACC_W    (ACC_W)
    ) dut (
        .Clk_i         (clk),
        .GlobalReset_i (rst),
        .Weight_i      (weight),
        .Pixel_i       (pixel),
        .Mult_en_i     (mult_en),
        .Add_en_i      (add_en),
        .Out_o         (out)
    );

    always #5 clk = ~clk;

    function automatic longint clamp(input longint v);
        if (v > MAX_V) return MAX_V;
        if (v < MIN_V) return MIN_V;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pending = 0;
            m_acc     = 0;
            m_valid   = 1'b1;
        end else begin
            if (add_en) m_acc = clamp(m_acc + m_pending);
            m_pending = mult_en ? longint'(weight) * longint'(pixel) : 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) check("cycle", longint'(out), m_acc);
    end

    task automatic drive(input bit r, input bit me, input bit ae,
                         input longint w, input longint p);
        rst     = r;
        mult_en = me;
        add_en  = ae;
        weight  = WEIGHT_W'(w);
        pixel   = PIXEL_W'(p);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Triangular accumulation with pixel 1
        drive(1, 0, 0, 0, 0);
        check("reset_out", longint'(out), 0);
        for (int k = 1; k <= 800; k++) begin
            drive(0, 1, 1, k, 1);
            if (k == 4) check("tri_after_3", longint'(out), 6);
        end
        drive(0, 0, 1, 0, 0);
        check("tri_800", longint'(out), 320400);
        check("model_tri_800", m_acc, 320400);

        // Positive saturation and hold at the ceiling
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 262143, 1023);
        drive(0, 0, 1, 0, 0);
        check("sat_pos", longint'(out), 33554431);
        drive(0, 1, 1, 262143, 1023);
        drive(0, 1, 1, 262143, 1023);
        drive(0, 0, 1, 0, 0);
        check("sat_pos_stay", longint'(out), 33554431);

        // Negative saturation, then accumulation continues from the clamp
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, -262144, 1023);
        drive(0, 1, 1, 1, 5);
        check("sat_neg", longint'(out), -33554432);
        drive(0, 0, 1, 0, 0);
        check("sat_neg_recover", longint'(out), -33554427);
        check("model_sat_neg", m_acc, -33554427);

        // Enable independence around a value of 100
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 10, 10);
        drive(0, 0, 1, 0, 0);
        check("load_100", longint'(out), 100);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0);
            check("mult_off_hold", longint'(out), 100);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 7, 3);
            check("add_off_hold", longint'(out), 100);
        end
        drive(0, 0, 1, 0, 0);
        check("add_21", longint'(out), 121);

        // Mid-stream reset pulse discards the pending product
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 1000 + i, 3);
        drive(1, 1, 1, 999, 999);
        check("midstream_reset", longint'(out), 0);
        drive(0, 1, 1, 5, 2);
        check("no_stale_product", longint'(out), 0);
        drive(0, 0, 1, 0, 0);
        check("resume_10", longint'(out), 10);

        // Randomized stream, biased toward large operands to reach both rails
        for (int i = 0; i < 4000; i++) begin
            longint w;
            longint p;
            w = longint'($signed(WEIGHT_W'($urandom)));
            p = longint'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) w = w / 64;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, w, p);
        end

        drive(0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_neuron
